// File: rtl/frame_edge_bit_pkg.sv
// Shared types and constants for the frame edge/bit timer.
package frame_edge_bit_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int PRESCALE_MIN        = 3;
   localparam int DEFAULT_PRESCALE_W  = 6;
   localparam int DEFAULT_BIT_CNT_W   = 4;

endpackage

// File: rtl/prescale_edge_counter.sv
// Modulo-N edge counter: load latches N and zeroes the count, wrap flags the last edge of a bit.
module prescale_edge_counter #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_value,
   output logic [W-1:0] count,
   output logic [W-1:0] modulus,
   output logic         wrap
);

   logic [W-1:0] count_reg;
   logic [W-1:0] modulus_reg;
   logic [W-1:0] last_edge;

   // modulus_reg is never below 3 once loaded, so the subtraction cannot underflow while counting
   assign last_edge = modulus_reg - W'(1);
   assign wrap      = en && (count_reg == last_edge);

   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg   <= '0;
         modulus_reg <= '0;
      end else if (clear) begin
         count_reg   <= '0;
      end else if (load) begin
         count_reg   <= '0;
         modulus_reg <= load_value;
      end else if (wrap) begin
         count_reg   <= '0;
      end else if (en) begin
         count_reg   <= count_reg + W'(1);
      end
   end

   assign count   = count_reg;
   assign modulus = modulus_reg;

endmodule

// File: rtl/frame_edge_bit_timer.sv
// Frame bit timer: counts prescaled edges per bit and bits per frame, with abort/restart.
// Optional majority-sample strobes are enabled by FRAME_EDGE_BIT_TIMER_SAMPLE_STROBE_EN.
module frame_edge_bit_timer
   import frame_edge_bit_pkg::*;
#(
   parameter int PRESCALE_W = DEFAULT_PRESCALE_W,
   parameter int BIT_CNT_W  = DEFAULT_BIT_CNT_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [PRESCALE_W-1:0] prescale_in,
   input  logic [BIT_CNT_W-1:0]  frame_bits_in,
   input  logic                  start_in,
   input  logic                  en_in,
   input  logic                  abort_in,
   output logic [PRESCALE_W-1:0] edge_cnt_out,
   output logic [BIT_CNT_W-1:0]  bit_cnt_out,
   output logic                  busy_out,
   output logic                  bit_tick_out,
   output logic                  frame_done_out,
   output logic                  cfg_err_out,
   output logic                  sample_strobe_out,
   output logic [1:0]            sample_idx_out
);

   state_t                state_reg, state_next;
   logic [BIT_CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
   logic [BIT_CNT_W-1:0]  frame_bits_reg, frame_bits_next;
   logic                  bit_tick_reg, bit_tick_next;
   logic                  frame_done_reg, frame_done_next;
   logic                  cfg_err_reg, cfg_err_next;

   logic                  cfg_ok;
   logic                  edge_en;
   logic                  edge_wrap;
   logic [PRESCALE_W-1:0] edge_cnt;
   logic [PRESCALE_W-1:0] prescale_q;

   assign cfg_ok  = (prescale_in >= PRESCALE_W'(PRESCALE_MIN)) && (frame_bits_in != '0);
   // Any start (even a rejected one) or abort pre-empts counting for that cycle
   assign edge_en = (state_reg == RUN) && en_in && !abort_in && !start_in;

   prescale_edge_counter #(
      .W(PRESCALE_W)
   ) u_edge_counter (
      .clk        (clk),
      .reset      (reset),
      .clear      (abort_in),
      .load       (!abort_in && start_in && cfg_ok),
      .en         (edge_en),
      .load_value (prescale_in),
      .count      (edge_cnt),
      .modulus    (prescale_q),
      .wrap       (edge_wrap)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         bit_cnt_reg    <= '0;
         frame_bits_reg <= '0;
         bit_tick_reg   <= 1'b0;
         frame_done_reg <= 1'b0;
         cfg_err_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         bit_cnt_reg    <= bit_cnt_next;
         frame_bits_reg <= frame_bits_next;
         bit_tick_reg   <= bit_tick_next;
         frame_done_reg <= frame_done_next;
         cfg_err_reg    <= cfg_err_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      bit_cnt_next    = bit_cnt_reg;
      frame_bits_next = frame_bits_reg;
      bit_tick_next   = 1'b0;
      frame_done_next = 1'b0;
      cfg_err_next    = 1'b0;
      if (abort_in) begin
         state_next   = IDLE;
         bit_cnt_next = '0;
      end else if (start_in) begin
         if (cfg_ok) begin
            state_next      = RUN;
            bit_cnt_next    = '0;
            frame_bits_next = frame_bits_in;
         end else begin
            cfg_err_next = 1'b1;
         end
      end else if (edge_wrap) begin
         bit_tick_next = 1'b1;
         if (bit_cnt_reg == frame_bits_reg - BIT_CNT_W'(1)) begin
            bit_cnt_next    = '0;
            state_next      = IDLE;
            frame_done_next = 1'b1;
         end else begin
            bit_cnt_next = bit_cnt_reg + BIT_CNT_W'(1);
         end
      end
   end

   assign edge_cnt_out   = edge_cnt;
   assign bit_cnt_out    = bit_cnt_reg;
   assign busy_out       = (state_reg == RUN);
   assign bit_tick_out   = bit_tick_reg;
   assign frame_done_out = frame_done_reg;
   assign cfg_err_out    = cfg_err_reg;

`ifdef FRAME_EDGE_BIT_TIMER_SAMPLE_STROBE_EN
   logic [PRESCALE_W-1:0] mid;
   assign mid = prescale_q >> 1;

   // Three strobes centred on the middle of the bit for 2-of-3 voting downstream
   always_comb begin
      sample_strobe_out = 1'b0;
      sample_idx_out    = 2'd0;
      if (busy_out) begin
         if (edge_cnt == mid - PRESCALE_W'(1)) begin
            sample_strobe_out = 1'b1;
            sample_idx_out    = 2'd0;
         end else if (edge_cnt == mid) begin
            sample_strobe_out = 1'b1;
            sample_idx_out    = 2'd1;
         end else if (edge_cnt == mid + PRESCALE_W'(1)) begin
            sample_strobe_out = 1'b1;
            sample_idx_out    = 2'd2;
         end
      end
   end
`else
   logic prescale_q_unused;
   assign prescale_q_unused = ^prescale_q;
   assign sample_strobe_out = 1'b0;
   assign sample_idx_out    = 2'd0;
`endif

endmodule

// File: tb/tb_frame_edge_bit_timer.sv
// Directed bench for frame_edge_bit_timer; strobe expectations follow FRAME_EDGE_BIT_TIMER_SAMPLE_STROBE_EN.
module tb_frame_edge_bit_timer;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] prescale_in;
   logic [3:0] frame_bits_in;
   logic       start_in, en_in, abort_in;
   logic [5:0] edge_cnt_out;
   logic [3:0] bit_cnt_out;
   logic       busy_out, bit_tick_out, frame_done_out, cfg_err_out;
   logic       sample_strobe_out;
   logic [1:0] sample_idx_out;

   int checks_total  = 0;
   int checks_passed = 0;

   always #5 clk = ~clk;

   frame_edge_bit_timer dut (
      .clk               (clk),
      .reset             (reset),
      .prescale_in       (prescale_in),
      .frame_bits_in     (frame_bits_in),
      .start_in          (start_in),
      .en_in             (en_in),
      .abort_in          (abort_in),
      .edge_cnt_out      (edge_cnt_out),
      .bit_cnt_out       (bit_cnt_out),
      .busy_out          (busy_out),
      .bit_tick_out      (bit_tick_out),
      .frame_done_out    (frame_done_out),
      .cfg_err_out       (cfg_err_out),
      .sample_strobe_out (sample_strobe_out),
      .sample_idx_out    (sample_idx_out)
   );

   // {busy, tick, done, cfg_err, edge[5:0], bit[3:0]}
   logic [13:0] obs;
   assign obs = {busy_out, bit_tick_out, frame_done_out, cfg_err_out, edge_cnt_out, bit_cnt_out};

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic start_frame(input logic [5:0] p, input logic [3:0] f);
      prescale_in   = p;
      frame_bits_in = f;
      en_in         = 1'b1;
      start_in      = 1'b1;
      step();
      start_in      = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start_in = 1'b0; en_in = 1'b1; abort_in = 1'b0;
      prescale_in = 6'd8; frame_bits_in = 4'd10;
      step(); step();
      checks_total++;
      if (obs !== 14'd0) $display("FAIL reset_state: got %b expected %b", obs, 14'd0);
      else checks_passed++;
      reset = 1'b0;
      step();
      checks_total++;
      if (obs !== 14'd0) $display("FAIL idle_after_reset: got %b expected %b", obs, 14'd0);
      else checks_passed++;
   endtask

   task automatic test_full_frame();
      logic [13:0] exp;
      start_frame(6'd8, 4'd10);
      exp = {4'b1000, 6'd0, 4'd0};
      checks_total++;
      if (obs !== exp) $display("FAIL full_start: got %b expected %b", obs, exp);
      else checks_passed++;
      // New config mid-frame must not disturb the running frame
      prescale_in = 6'd3; frame_bits_in = 4'd1;
      for (int c = 1; c <= 84; c++) begin
         step();
         exp = {(c < 80), (c % 8 == 0 && c <= 80), (c == 80), 1'b0,
                (c < 80) ? 6'(c % 8) : 6'd0, (c < 80) ? 4'(c / 8) : 4'd0};
         checks_total++;
         if (obs !== exp) $display("FAIL full_frame c=%0d: got %b expected %b", c, obs, exp);
         else checks_passed++;
      end
   endtask

   task automatic test_enable_hold();
      int cycles, ticks, done_at, held_bad;
      start_frame(6'd16, 4'd10);
      repeat (5) step();
      checks_total++;
      if (edge_cnt_out !== 6'd5) $display("FAIL hold_pre_edge: got %0d expected 5", edge_cnt_out);
      else checks_passed++;
      en_in = 1'b0;
      held_bad = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (obs !== {4'b1000, 6'd5, 4'd0}) held_bad++;
      end
      checks_total++;
      if (held_bad !== 0) $display("FAIL hold_frozen: got %0d bad cycles expected 0", held_bad);
      else checks_passed++;
      en_in = 1'b1;
      cycles = 9; ticks = 0; done_at = 0;
      while (cycles < 400 && done_at == 0) begin
         step();
         cycles++;
         if (bit_tick_out) ticks++;
         if (frame_done_out) done_at = cycles;
      end
      checks_total++;
      if (done_at !== 164) $display("FAIL hold_frame_len: got %0d expected 164", done_at);
      else checks_passed++;
      checks_total++;
      if (ticks !== 10) $display("FAIL hold_ticks: got %0d expected 10", ticks);
      else checks_passed++;
   endtask

   task automatic test_restart();
      int ticks, done_at, early_done;
      start_frame(6'd8, 4'd10);
      repeat (27) step();
      checks_total++;
      if (obs !== {4'b1000, 6'd3, 4'd3}) $display("FAIL restart_pre: got %b expected %b", obs, {4'b1000, 6'd3, 4'd3});
      else checks_passed++;
      start_frame(6'd8, 4'd10);
      checks_total++;
      if (obs !== {4'b1000, 6'd0, 4'd0}) $display("FAIL restart_clear: got %b expected %b", obs, {4'b1000, 6'd0, 4'd0});
      else checks_passed++;
      ticks = 0; done_at = 0; early_done = 0;
      for (int c = 1; c <= 80; c++) begin
         step();
         if (bit_tick_out) ticks++;
         if (frame_done_out) begin
            if (c != 80) early_done++;
            done_at = c;
         end
      end
      checks_total++;
      if (done_at !== 80 || early_done !== 0)
         $display("FAIL restart_done: got done at %0d (early %0d) expected 80 (early 0)", done_at, early_done);
      else checks_passed++;
      checks_total++;
      if (ticks !== 10) $display("FAIL restart_ticks: got %0d expected 10", ticks);
      else checks_passed++;
   endtask

   task automatic test_cfg_err();
      start_frame(6'd2, 4'd10);
      checks_total++;
      if ({cfg_err_out, busy_out} !== 2'b10) $display("FAIL cfg_prescale2: got %b expected 10", {cfg_err_out, busy_out});
      else checks_passed++;
      step();
      checks_total++;
      if ({cfg_err_out, busy_out} !== 2'b00) $display("FAIL cfg_pulse_width: got %b expected 00", {cfg_err_out, busy_out});
      else checks_passed++;
      start_frame(6'd8, 4'd0);
      checks_total++;
      if ({cfg_err_out, busy_out} !== 2'b10) $display("FAIL cfg_bits0: got %b expected 10", {cfg_err_out, busy_out});
      else checks_passed++;
      // Minimum legal prescale with a one-bit frame
      start_frame(6'd3, 4'd1);
      checks_total++;
      if (obs !== {4'b1000, 6'd0, 4'd0}) $display("FAIL cfg_min_start: got %b expected %b", obs, {4'b1000, 6'd0, 4'd0});
      else checks_passed++;
      step(); step();
      checks_total++;
      if (obs !== {4'b1000, 6'd2, 4'd0}) $display("FAIL cfg_min_mid: got %b expected %b", obs, {4'b1000, 6'd2, 4'd0});
      else checks_passed++;
      step();
      checks_total++;
      if (obs !== {4'b0110, 6'd0, 4'd0}) $display("FAIL cfg_min_done: got %b expected %b", obs, {4'b0110, 6'd0, 4'd0});
      else checks_passed++;
      // Rejected start while running leaves the frame untouched
      start_frame(6'd8, 4'd10);
      step(); step();
      start_frame(6'd2, 4'd5);
      checks_total++;
      if (obs !== {4'b1001, 6'd2, 4'd0}) $display("FAIL cfg_reject_run: got %b expected %b", obs, {4'b1001, 6'd2, 4'd0});
      else checks_passed++;
      abort_in = 1'b1; step(); abort_in = 1'b0;
   endtask

   task automatic test_abort();
      int pulses;
      start_frame(6'd8, 4'd10);
      repeat (39) step();
      checks_total++;
      if (obs !== {4'b1000, 6'd7, 4'd4}) $display("FAIL abort_pre: got %b expected %b", obs, {4'b1000, 6'd7, 4'd4});
      else checks_passed++;
      abort_in = 1'b1;
      step();
      abort_in = 1'b0;
      checks_total++;
      if (obs !== 14'd0) $display("FAIL abort_idle: got %b expected %b", obs, 14'd0);
      else checks_passed++;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (bit_tick_out || frame_done_out || busy_out) pulses++;
      end
      checks_total++;
      if (pulses !== 0) $display("FAIL abort_quiet: got %0d active cycles expected 0", pulses);
      else checks_passed++;
   endtask

   task automatic test_sample_strobe();
      int bad;
      int e;
      logic       exp_strobe;
      logic [1:0] exp_idx;
      start_frame(6'd16, 4'd2);
      bad = 0;
      for (int c = 1; c <= 34; c++) begin
         step();
         e = (c < 32) ? (c % 16) : 0;
`ifdef FRAME_EDGE_BIT_TIMER_SAMPLE_STROBE_EN
         exp_strobe = (c < 32) && (e >= 7) && (e <= 9);
         exp_idx    = exp_strobe ? 2'(e - 7) : 2'd0;
`else
         exp_strobe = 1'b0;
         exp_idx    = 2'd0;
`endif
         checks_total++;
         if ({sample_strobe_out, sample_idx_out} !== {exp_strobe, exp_idx})
            $display("FAIL strobe c=%0d: got %b/%0d expected %b/%0d", c, sample_strobe_out, sample_idx_out, exp_strobe, exp_idx);
         else checks_passed++;
         if (edge_cnt_out !== 6'(e)) bad++;
      end
      checks_total++;
      if (bad !== 0) $display("FAIL strobe_edges: got %0d wrong edge cycles expected 0", bad);
      else checks_passed++;
   endtask

   task automatic test_reset_mid_frame();
      int pulses;
      start_frame(6'd8, 4'd10);
      repeat (55) step();
      checks_total++;
      if (obs !== {4'b1000, 6'd7, 4'd6}) $display("FAIL rst_mid_pre: got %b expected %b", obs, {4'b1000, 6'd7, 4'd6});
      else checks_passed++;
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks_total++;
      if (obs !== 14'd0) $display("FAIL rst_mid_clear: got %b expected %b", obs, 14'd0);
      else checks_passed++;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (obs !== 14'd0) pulses++;
      end
      checks_total++;
      if (pulses !== 0) $display("FAIL rst_mid_quiet: got %0d active cycles expected 0", pulses);
      else checks_passed++;
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_enable_hold();
      test_restart();
      test_cfg_err();
      test_abort();
      test_sample_strobe();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
